// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//   Game-flow controller for the pong graphics block. It watches the
//   per-player miss flags and the frame tick, keeps both scores and sequences
//   IDLE -> SERVE -> PLAY -> (SERVE | OVER). It drives 'still', which freezes
//   the paddles and recentres the ball in every state except PLAY.
//
// Optional feature (macro AUTO_RESTART_EN):
//   When defined, OVER counts OVER_FRAMES frame ticks and then starts a new
//   game straight into SERVE. A start edge in OVER still goes to IDLE and
//   wins over the timer in the same cycle. When undefined, OVER exits only
//   on a start edge and OVER_FRAMES is unused.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   debounced start button (level, rising edge used)
//   frame_tick in   one-cycle pulse per frame
//   miss1      in   level, player 1 missed the ball
//   miss2      in   level, player 2 missed the ball
//   still      out  freeze game / recentre ball
//   score1     out  player 1 score, 0..WIN_SCORE
//   score2     out  player 2 score, 0..WIN_SCORE
//   game_over  out  high while in OVER
//   winner     out  00 none, 01 player 1, 10 player 2
//   state_o    out  IDLE=0, SERVE=1, PLAY=2, OVER=3
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int OVER_FRAMES  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss1,
  input  logic       miss2,
  output logic       still,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (WIN_SCORE < 1 || WIN_SCORE > 9 || SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
      OVER_FRAMES < 1 || OVER_FRAMES > 255) begin : g_bad_params
    $error("pong_game_ctrl: parameter out of legal range");
  end

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [3:0] r_score1, w_score1_next;
  logic [3:0] r_score2, w_score2_next;
  logic [1:0] r_winner, w_winner_next;
  logic       r_still;
  logic       r_game_over;
  logic       r_start_q, r_miss1_q, r_miss2_q;

  logic       w_start_e, w_miss1_e, w_miss2_e;
  logic [3:0] w_score1_inc, w_score2_inc;

  assign w_start_e    = start & ~r_start_q;
  assign w_miss1_e    = miss1 & ~r_miss1_q;
  assign w_miss2_e    = miss2 & ~r_miss2_q;
  assign w_score1_inc = r_score1 + 4'd1;
  assign w_score2_inc = r_score2 + 4'd1;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_score1_next = r_score1;
    w_score2_next = r_score2;
    w_winner_next = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (w_start_e) begin
          w_score1_next = '0;
          w_score2_next = '0;
          w_winner_next = 2'b00;
          w_cnt_next    = '0;
          w_state_next  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (r_cnt == SERVE_LAST) begin
            w_cnt_next   = '0;
            w_state_next = ST_PLAY;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        // miss1 wins when both players miss in the same cycle.
        if (w_miss1_e) begin
          w_score2_next = w_score2_inc;
          w_cnt_next    = '0;
          if (w_score2_inc == WIN_VAL) begin
            w_winner_next = 2'b10;
            w_state_next  = ST_OVER;
          end else begin
            w_state_next = ST_SERVE;
          end
        end else if (w_miss2_e) begin
          w_score1_next = w_score1_inc;
          w_cnt_next    = '0;
          if (w_score1_inc == WIN_VAL) begin
            w_winner_next = 2'b01;
            w_state_next  = ST_OVER;
          end else begin
            w_state_next = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
`ifdef AUTO_RESTART_EN
        if (w_start_e) begin
          w_state_next = ST_IDLE;
        end else if (frame_tick) begin
          if (r_cnt == 8'(OVER_FRAMES - 1)) begin
            w_score1_next = '0;
            w_score2_next = '0;
            w_winner_next = 2'b00;
            w_cnt_next    = '0;
            w_state_next  = ST_SERVE;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
`else
        if (w_start_e) begin
          w_state_next = ST_IDLE;
        end
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_score1    <= '0;
      r_score2    <= '0;
      r_winner    <= 2'b00;
      r_still     <= 1'b1;
      r_game_over <= 1'b0;
      r_start_q   <= 1'b0;
      r_miss1_q   <= 1'b0;
      r_miss2_q   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_score1    <= w_score1_next;
      r_score2    <= w_score2_next;
      r_winner    <= w_winner_next;
      // Decoded from the next state so they line up with state_o.
      r_still     <= (w_state_next != ST_PLAY);
      r_game_over <= (w_state_next == ST_OVER);
      r_start_q   <= start;
      r_miss1_q   <= miss1;
      r_miss2_q   <= miss2;
    end
  end

  assign still     = r_still;
  assign score1    = r_score1;
  assign score2    = r_score2;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign state_o   = r_state;

endmodule
